// File: rtl/shift_rows_pkg.sv
// Shared definitions for the ShiftRows pipeline: legal block sizes,
// per-row rotation amounts and the column-major byte numbering.
package shift_rows_pkg;

    // Block column counts the permutation is defined for.
    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Row rotation amount: 0,1,2,3 for 4/6 columns, 0,1,3,4 for 8 columns.
    function automatic int row_off(input int nb, input int r);
        if ((nb == 8) && (r >= 2)) begin
            return r + 1;
        end
        return r;
    endfunction

    // Column-major byte number of (row, col); byte 0 sits at the MSB end.
    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation for an NB-column block.
// Every output byte is a fixed 2:1 choice between its forward and inverse
// source byte, so the whole network is just wiring plus one mux per byte.
module shift_rows_perm
    import shift_rows_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data_in,
    input  logic             inv,
    output logic [32*NB-1:0] data_out
);

    localparam int W = 32 * NB;

    genvar gi;
    generate
        for (gi = 0; gi < 4 * NB; gi++) begin : g_byte
            localparam int R       = gi % 4;
            localparam int C       = gi / 4;
            localparam int OFF     = row_off(NB, R);
            localparam int FWD_C   = (C + OFF) % NB;
            localparam int INV_C   = (C - OFF + NB) % NB;
            localparam int DST     = W - 1 - 8 * byte_idx(R, C);
            localparam int FWD_SRC = W - 1 - 8 * byte_idx(R, FWD_C);
            localparam int INV_SRC = W - 1 - 8 * byte_idx(R, INV_C);

            assign data_out[DST -: 8] = inv ? data_in[INV_SRC -: 8]
                                            : data_in[FWD_SRC -: 8];
        end
    endgenerate

endmodule

// File: rtl/shift_rows_pipe.sv
// One-cycle (Inv)ShiftRows stage with a valid/ready handshake on both
// sides. A main output register plus a single skid register lets in_ready
// be registered while still sustaining one block per cycle.
module shift_rows_pipe
    import shift_rows_pkg::*;
#(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              out_inv,
    output logic [CNT_W-1:0]  blk_cnt
);

    localparam int W = 32 * NB;

    generate
        if (!nb_legal(NB)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    logic [W-1:0]     perm_data;
    logic [W-1:0]     main_data_reg, main_data_next;
    logic             main_inv_reg, main_inv_next;
    logic             main_valid_reg, main_valid_next;
    logic [W-1:0]     skid_data_reg, skid_data_next;
    logic             skid_inv_reg, skid_inv_next;
    logic             skid_valid_reg, skid_valid_next;
    logic             in_ready_reg, in_ready_next;
    logic [CNT_W-1:0] blk_cnt_reg, blk_cnt_next;
    logic             in_fire;
    logic             main_free;

    // Permute before registering so the result is ready one edge later.
    shift_rows_perm #(
        .NB(NB)
    ) u_perm (
        .data_in  (in_data),
        .inv      (in_inv),
        .data_out (perm_data)
    );

    // Next-state: the skid entry always refills main ahead of new input;
    // new input lands in skid only while main is stalled.
    always_comb begin
        main_data_next  = main_data_reg;
        main_inv_next   = main_inv_reg;
        main_valid_next = main_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_inv_next   = skid_inv_reg;
        skid_valid_next = skid_valid_reg;
        in_fire         = in_valid && in_ready_reg;
        main_free       = !main_valid_reg || out_ready;

        if (main_free) begin
            if (skid_valid_reg) begin
                main_data_next  = skid_data_reg;
                main_inv_next   = skid_inv_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (in_fire) begin
                main_data_next  = perm_data;
                main_inv_next   = in_inv;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            skid_data_next  = perm_data;
            skid_inv_next   = in_inv;
            skid_valid_next = 1'b1;
        end

        in_ready_next = !skid_valid_next;
        blk_cnt_next  = in_fire ? blk_cnt_reg + CNT_W'(1) : blk_cnt_reg;
    end

    // State registers; reset clears both stages and holds off input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_reg  <= '0;
            main_inv_reg   <= 1'b0;
            main_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_inv_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b0;
            blk_cnt_reg    <= '0;
        end else begin
            main_data_reg  <= main_data_next;
            main_inv_reg   <= main_inv_next;
            main_valid_reg <= main_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_inv_reg   <= skid_inv_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= in_ready_next;
            blk_cnt_reg    <= blk_cnt_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;
    assign out_inv   = main_inv_reg;
    assign blk_cnt   = blk_cnt_reg;

endmodule
